// File: rtl/regfile_sb.sv
// RV32I integer register file (x1..x31) with per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data and in-flight decrements to ID.
module regfile_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned SB_CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Ctl_RegWrite_in,
  input  logic [4:0]      Rd_in,
  input  logic [XLEN-1:0] WriteDatatoReg_in,
  input  logic [4:0]      Rs1_in,
  input  logic [4:0]      Rs2_in,
  output logic [XLEN-1:0] ReadData1_out,
  output logic [XLEN-1:0] ReadData2_out,
  input  logic            Issue_valid_in,
  input  logic            Issue_RegWrite_in,
  input  logic [4:0]      Issue_Rd_in,
  input  logic            Flush_in,
  output logic            Hazard_stall_out,
  output logic            Sb_err_out
);

  localparam logic [SB_CNT_W-1:0] CntMax = '1;
  localparam logic [SB_CNT_W-1:0] CntOne = SB_CNT_W'(1);

  logic [XLEN-1:0]     regs_q [1:31];
  logic [SB_CNT_W-1:0] cnt_q  [1:31];
  logic [SB_CNT_W-1:0] cnt_d  [1:31];
  logic                err_q, err_d;
  logic                wb_en, inc;
  logic                pend1, pend2;

  assign wb_en = Ctl_RegWrite_in & (Rd_in != 5'd0);
  assign inc   = Issue_valid_in & Issue_RegWrite_in & (Issue_Rd_in != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
    end else if (wb_en) begin
      regs_q[Rd_in] <= WriteDatatoReg_in;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (Flush_in) begin
      // Flush drops every pending count; the concurrent issue and WB decrement are discarded.
      for (int i = 1; i < 32; i++) cnt_d[i] = '0;
    end else if (!(inc && wb_en && (Issue_Rd_in == Rd_in))) begin
      if (inc) begin
        if (cnt_q[Issue_Rd_in] == CntMax) err_d = 1'b1;
        else cnt_d[Issue_Rd_in] = cnt_q[Issue_Rd_in] + CntOne;
      end
      if (wb_en) begin
        if (cnt_q[Rd_in] == '0) err_d = 1'b1;
        else cnt_d[Rd_in] = cnt_q[Rd_in] - CntOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) cnt_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign Sb_err_out = err_q;

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    if (Rs1_in == 5'd0)                    ReadData1_out = '0;
    else if (wb_en && (Rd_in == Rs1_in))   ReadData1_out = WriteDatatoReg_in;
    else                                   ReadData1_out = regs_q[Rs1_in];
    if (Rs2_in == 5'd0)                    ReadData2_out = '0;
    else if (wb_en && (Rd_in == Rs2_in))   ReadData2_out = WriteDatatoReg_in;
    else                                   ReadData2_out = regs_q[Rs2_in];
  end

  // A register whose last outstanding write is retiring right now is already readable.
  always_comb begin
    pend1 = (Rs1_in != 5'd0) && (cnt_q[Rs1_in] != '0) &&
            !((cnt_q[Rs1_in] == CntOne) && wb_en && (Rd_in == Rs1_in));
    pend2 = (Rs2_in != 5'd0) && (cnt_q[Rs2_in] != '0) &&
            !((cnt_q[Rs2_in] == CntOne) && wb_en && (Rd_in == Rs2_in));
  end
`else
  always_comb begin
    ReadData1_out = (Rs1_in == 5'd0) ? '0 : regs_q[Rs1_in];
    ReadData2_out = (Rs2_in == 5'd0) ? '0 : regs_q[Rs2_in];
  end

  always_comb begin
    pend1 = (Rs1_in != 5'd0) && (cnt_q[Rs1_in] != '0);
    pend2 = (Rs2_in != 5'd0) && (cnt_q[Rs2_in] != '0);
  end
`endif

  assign Hazard_stall_out = pend1 | pend2;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb; expected values queued at stimulus time, popped at sampling.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic        Ctl_RegWrite_in;
  logic [4:0]  Rd_in;
  logic [31:0] WriteDatatoReg_in;
  logic [4:0]  Rs1_in, Rs2_in;
  logic [31:0] ReadData1_out, ReadData2_out;
  logic        Issue_valid_in, Issue_RegWrite_in;
  logic [4:0]  Issue_Rd_in;
  logic        Flush_in;
  logic        Hazard_stall_out, Sb_err_out;

  logic [31:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  regfile_sb #(.XLEN(32), .SB_CNT_W(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .Ctl_RegWrite_in  (Ctl_RegWrite_in),
    .Rd_in            (Rd_in),
    .WriteDatatoReg_in(WriteDatatoReg_in),
    .Rs1_in           (Rs1_in),
    .Rs2_in           (Rs2_in),
    .ReadData1_out    (ReadData1_out),
    .ReadData2_out    (ReadData2_out),
    .Issue_valid_in   (Issue_valid_in),
    .Issue_RegWrite_in(Issue_RegWrite_in),
    .Issue_Rd_in      (Issue_Rd_in),
    .Flush_in         (Flush_in),
    .Hazard_stall_out (Hazard_stall_out),
    .Sb_err_out       (Sb_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic idle();
    Ctl_RegWrite_in = 0; Rd_in = 0; WriteDatatoReg_in = 0;
    Rs1_in = 0; Rs2_in = 0;
    Issue_valid_in = 0; Issue_RegWrite_in = 0; Issue_Rd_in = 0;
    Flush_in = 0;
  endtask

  task automatic clk_edge();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic issue(input logic [4:0] rd);
    Issue_valid_in = 1; Issue_RegWrite_in = 1; Issue_Rd_in = rd;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    Ctl_RegWrite_in = 1; Rd_in = rd; WriteDatatoReg_in = d;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    rst_n = 0;
    do_reset();
    Rs1_in = 5;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (ReadData1_out !== e) begin errors++; $display("FAIL init_rd1 got=%h exp=%h", ReadData1_out, e); end
    e = exp_q.pop_front(); checks++;
    if (Hazard_stall_out !== e[0]) begin errors++; $display("FAIL init_stall got=%b exp=%b", Hazard_stall_out, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (Sb_err_out !== e[0]) begin errors++; $display("FAIL init_err got=%b exp=%b", Sb_err_out, e[0]); end
    clk_edge();
    issue(5); clk_edge();
    wb(5, 32'h1234); issue(5); clk_edge();
    wb(6, 32'h0); clk_edge();
    Rs1_in = 5;
    exp_q.push_back(32'h1234); exp_q.push_back(32'h1); exp_q.push_back(32'h1);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (ReadData1_out !== e) begin errors++; $display("FAIL pre_rst_rd1 got=%h exp=%h", ReadData1_out, e); end
    e = exp_q.pop_front(); checks++;
    if (Hazard_stall_out !== e[0]) begin errors++; $display("FAIL pre_rst_stall got=%b exp=%b", Hazard_stall_out, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (Sb_err_out !== e[0]) begin errors++; $display("FAIL pre_rst_err got=%b exp=%b", Sb_err_out, e[0]); end
    #2 rst_n = 0;
    #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); checks++;
    if (ReadData1_out !== e) begin errors++; $display("FAIL async_rst_rd1 got=%h exp=%h", ReadData1_out, e); end
    e = exp_q.pop_front(); checks++;
    if (Hazard_stall_out !== e[0]) begin errors++; $display("FAIL async_rst_stall got=%b exp=%b", Hazard_stall_out, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (Sb_err_out !== e[0]) begin errors++; $display("FAIL async_rst_err got=%b exp=%b", Sb_err_out, e[0]); end
    @(negedge clk);
    rst_n = 1;
    clk_edge();
  endtask

  task automatic test_x0();
    logic [31:0] e;
    wb(0, 32'hFFFF_FFFF); issue(0); Rs1_in = 0;
    exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (ReadData1_out !== e) begin errors++; $display("FAIL x0_same_cycle got=%h exp=%h", ReadData1_out, e); end
    clk_edge();
    Rs1_in = 0; Rs2_in = 0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (ReadData1_out !== e) begin errors++; $display("FAIL x0_rd1 got=%h exp=%h", ReadData1_out, e); end
    e = exp_q.pop_front(); checks++;
    if (ReadData2_out !== e) begin errors++; $display("FAIL x0_rd2 got=%h exp=%h", ReadData2_out, e); end
    e = exp_q.pop_front(); checks++;
    if (Hazard_stall_out !== e[0]) begin errors++; $display("FAIL x0_stall got=%b exp=%b", Hazard_stall_out, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (Sb_err_out !== e[0]) begin errors++; $display("FAIL x0_err got=%b exp=%b", Sb_err_out, e[0]); end
    clk_edge();
  endtask

  task automatic test_basic();
    logic [31:0] e;
    issue(7); clk_edge();
    wb(7, 32'hDEAD_BEEF); clk_edge();
    Rs2_in = 7; Rs1_in = 7;
    exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (ReadData2_out !== e) begin errors++; $display("FAIL basic_rd2 got=%h exp=%h", ReadData2_out, e); end
    e = exp_q.pop_front(); checks++;
    if (ReadData1_out !== e) begin errors++; $display("FAIL basic_rd1 got=%h exp=%h", ReadData1_out, e); end
    e = exp_q.pop_front(); checks++;
    if (Hazard_stall_out !== e[0]) begin errors++; $display("FAIL basic_stall got=%b exp=%b", Hazard_stall_out, e[0]); end
    clk_edge();
  endtask

  task automatic test_bypass();
    logic [31:0] e;
    issue(3); clk_edge();
    wb(3, 32'hA5A5_A5A5); Rs1_in = 3;
    exp_q.push_back(Bypass ? 32'hA5A5_A5A5 : 32'h0);
    exp_q.push_back(Bypass ? 32'h0 : 32'h1);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (ReadData1_out !== e) begin errors++; $display("FAIL bypass_rd1 got=%h exp=%h", ReadData1_out, e); end
    e = exp_q.pop_front(); checks++;
    if (Hazard_stall_out !== e[0]) begin errors++; $display("FAIL bypass_stall got=%b exp=%b", Hazard_stall_out, e[0]); end
    clk_edge();
    Rs1_in = 3;
    exp_q.push_back(32'hA5A5_A5A5); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (ReadData1_out !== e) begin errors++; $display("FAIL after_wb_rd1 got=%h exp=%h", ReadData1_out, e); end
    e = exp_q.pop_front(); checks++;
    if (Hazard_stall_out !== e[0]) begin errors++; $display("FAIL after_wb_stall got=%b exp=%b", Hazard_stall_out, e[0]); end
    clk_edge();
  endtask

  task automatic test_multi();
    logic [31:0] e;
    issue(9); clk_edge();
    issue(9); clk_edge();
    // count 2: first WB keeps the stall in every configuration
    Rs1_in = 9; wb(9, 32'h11);
    exp_q.push_back(32'h1);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (Hazard_stall_out !== e[0]) begin errors++; $display("FAIL multi_cnt2_stall got=%b exp=%b", Hazard_stall_out, e[0]); end
    clk_edge();
    Rs1_in = 9; issue(9); wb(9, 32'h22);
    exp_q.push_back(Bypass ? 32'h0 : 32'h1);
    exp_q.push_back(Bypass ? 32'h22 : 32'h11);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (Hazard_stall_out !== e[0]) begin errors++; $display("FAIL multi_simul_stall got=%b exp=%b", Hazard_stall_out, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (ReadData1_out !== e) begin errors++; $display("FAIL multi_simul_rd1 got=%h exp=%h", ReadData1_out, e); end
    clk_edge();
    Rs2_in = 9;
    exp_q.push_back(32'h1); exp_q.push_back(32'h22);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (Hazard_stall_out !== e[0]) begin errors++; $display("FAIL multi_cnt1_stall got=%b exp=%b", Hazard_stall_out, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (ReadData2_out !== e) begin errors++; $display("FAIL multi_cnt1_rd2 got=%h exp=%h", ReadData2_out, e); end
    clk_edge();
    Rs1_in = 9; wb(9, 32'h33);
    exp_q.push_back(Bypass ? 32'h0 : 32'h1);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (Hazard_stall_out !== e[0]) begin errors++; $display("FAIL multi_last_wb_stall got=%b exp=%b", Hazard_stall_out, e[0]); end
    clk_edge();
    Rs1_in = 9;
    exp_q.push_back(32'h0); exp_q.push_back(32'h33); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (Hazard_stall_out !== e[0]) begin errors++; $display("FAIL multi_clear_stall got=%b exp=%b", Hazard_stall_out, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (ReadData1_out !== e) begin errors++; $display("FAIL multi_clear_rd1 got=%h exp=%h", ReadData1_out, e); end
    e = exp_q.pop_front(); checks++;
    if (Sb_err_out !== e[0]) begin errors++; $display("FAIL multi_err got=%b exp=%b", Sb_err_out, e[0]); end
    clk_edge();
  endtask

  task automatic test_underflow();
    logic [31:0] e;
    do_reset();
    wb(6, 32'h66);
    exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (Sb_err_out !== e[0]) begin errors++; $display("FAIL uflow_before got=%b exp=%b", Sb_err_out, e[0]); end
    clk_edge();
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(32'h1);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (Sb_err_out !== e[0]) begin errors++; $display("FAIL uflow_sticky%0d got=%b exp=%b", k, Sb_err_out, e[0]); end
      clk_edge();
    end
  endtask

  task automatic test_overflow();
    logic [31:0] e;
    do_reset();
    for (int k = 0; k < 3; k++) begin issue(4); clk_edge(); end
    Rs1_in = 4;
    exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (Sb_err_out !== e[0]) begin errors++; $display("FAIL oflow_at_max_err got=%b exp=%b", Sb_err_out, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (Hazard_stall_out !== e[0]) begin errors++; $display("FAIL oflow_at_max_stall got=%b exp=%b", Hazard_stall_out, e[0]); end
    issue(4); Rs1_in = 4; clk_edge();
    // count held at 3: three retirements still leave it clear, not wrapped
    for (int k = 0; k < 3; k++) begin wb(4, 32'h44); clk_edge(); end
    Rs1_in = 4;
    exp_q.push_back(32'h1); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (Sb_err_out !== e[0]) begin errors++; $display("FAIL oflow_err got=%b exp=%b", Sb_err_out, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (Hazard_stall_out !== e[0]) begin errors++; $display("FAIL oflow_held_stall got=%b exp=%b", Hazard_stall_out, e[0]); end
    clk_edge();
  endtask

  task automatic test_flush();
    logic [31:0] e;
    do_reset();
    issue(4); clk_edge();
    issue(4); clk_edge();
    Rs1_in = 4;
    exp_q.push_back(32'h1);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (Hazard_stall_out !== e[0]) begin errors++; $display("FAIL flush_pre_stall got=%b exp=%b", Hazard_stall_out, e[0]); end
    Flush_in = 1; issue(4); wb(8, 32'h88);
    clk_edge();
    Rs1_in = 4; Rs2_in = 8;
    exp_q.push_back(32'h0); exp_q.push_back(32'h88); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (Hazard_stall_out !== e[0]) begin errors++; $display("FAIL flush_stall got=%b exp=%b", Hazard_stall_out, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (ReadData2_out !== e) begin errors++; $display("FAIL flush_wb_rd2 got=%h exp=%h", ReadData2_out, e); end
    e = exp_q.pop_front(); checks++;
    if (Sb_err_out !== e[0]) begin errors++; $display("FAIL flush_err got=%b exp=%b", Sb_err_out, e[0]); end
    issue(4); clk_edge();
    Rs2_in = 4;
    exp_q.push_back(32'h1);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (Hazard_stall_out !== e[0]) begin errors++; $display("FAIL post_flush_issue_stall got=%b exp=%b", Hazard_stall_out, e[0]); end
    clk_edge();
  endtask

  initial begin
    idle();
    test_reset();
    test_x0();
    test_basic();
    test_bypass();
    test_multi();
    test_underflow();
    test_overflow();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Integer register file with a pending-write scoreboard for the 5-stage RV32I core. It is the receiving end of the write-back interface: it consumes `Ctl_RegWrite`, `Rd` and `WriteDatatoReg` from the WB stage. It serves two combinational read ports to ID and tracks in-flight destination registers so ID can raise a RAW-hazard stall.

## Interface
Parameters:
- `XLEN`, 32, data width of each register.
- `SB_CNT_W`, 2, width of each per-register pending counter; maximum count is 2^SB_CNT_W−1.

Ports (clock and reset first; reset is asynchronous, active-low):
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `Ctl_RegWrite_in`  input  1  write enable from WB.
- `Rd_in`  input  5  write-back destination index.
- `WriteDatatoReg_in`  input  XLEN  write-back data.
- `Rs1_in`, `Rs2_in`  input  5 each  ID read indices.
- `ReadData1_out`, `ReadData2_out`  output  XLEN each  read data, combinational.
- `Issue_valid_in`  input  1  ID issues an instruction into EX this cycle (not stalled, not flushed).
- `Issue_RegWrite_in`  input  1  issued instruction writes a register.
- `Issue_Rd_in`  input  5  issued instruction's destination.
- `Flush_in`  input  1  pipeline flush; clears all pending counts.
- `Hazard_stall_out`  output  1  combinational; Rs1 or Rs2 has a pending write.
- `Sb_err_out`  output  1  sticky scoreboard protocol error.

## Operation
- Storage: 31 × XLEN flops for x1..x31. x0 always reads 0, is never written, and is never pending.
- Write: on a rising `clk` edge with `Ctl_RegWrite_in`=1 and `Rd_in`≠0, `regs[Rd_in]` ← `WriteDatatoReg_in`.
- Read: `ReadDataN_out` = `regs[RsN_in]`, or 0 if `RsN_in`=0. Same-cycle bypass is covered under Configuration.
- Scoreboard: one `SB_CNT_W`-bit counter per x1..x31.
  - `inc` = `Issue_valid_in` & `Issue_RegWrite_in` & (`Issue_Rd_in`≠0), applied to `Issue_Rd_in`.
  - `dec` = `Ctl_RegWrite_in` & (`Rd_in`≠0), applied to `Rd_in`.
  - Each edge: if inc and dec hit the same register, its count is unchanged. Otherwise the target of inc gets +1 and the target of dec gets −1.
  - Overflow: inc at max count holds the count and sets `Sb_err_out`.
  - Underflow: dec at count 0 holds 0 and sets `Sb_err_out`.
  - `Sb_err_out` stays set until reset.
- Flush: at the edge, all counters go to 0, and any inc that edge is ignored. The write-back register write still occurs; its dec is ignored, with no underflow error.
- Hazard: `Hazard_stall_out` = (`Rs1_in`≠0 & pending(`Rs1_in`)) | (`Rs2_in`≠0 & pending(`Rs2_in`)). pending(r) means count(r)≠0.

## Timing
- Reset (asynchronous assert, synchronous-safe release): all registers 0, all counters 0, `Sb_err_out`=0. `ReadData*_out` therefore read 0, and `Hazard_stall_out`=0.
- Write latency: written data is visible in `regs` in the cycle after the edge.
- Scoreboard latency: an issue at edge N makes the register pending from cycle N+1. A WB in cycle M clears it at edge M, so it is not pending from cycle M+1.
- Reset asserted mid-operation discards all writes and pending counts immediately, with no clock needed.

## Configuration
- `REGFILE_BYPASS_EN`, defined:
  - A read of index r in the same cycle as a write-back to r (r≠0) returns `WriteDatatoReg_in`.
  - pending(r) excludes the decrement in flight that cycle: r is treated as not pending when count(r)=1 and dec targets r.
  - ID can consume a value in the same cycle WB produces it.
- Not defined:
  - Reads return the stored value only.
  - pending(r) uses the registered count.
  - The consumer stalls one extra cycle.

## Test plan
- Reset: drive `rst_n`=0 mid-run after writing x5=0x1234 → `ReadData1_out`(Rs1=5)=0, `Hazard_stall_out`=0, `Sb_err_out`=0.
- x0: write x0=0xFFFFFFFF, then issue with Rd=0 → reads of x0 return 0, and no stall on Rs1=0.
- Basic write/read: write x7=0xDEADBEEF at edge N, Rs2=7 in cycle N+1 → `ReadData2_out`=0xDEADBEEF.
- Bypass, same cycle: WB writes x3=0xA5A5A5A5 while Rs1=3 and count(x3)=1.
  - With `REGFILE_BYPASS_EN`: data 0xA5A5A5A5 and stall 0.
  - Without it: old value and stall 1.
- Multiple writers:
  - Issue Rd=9 twice → count 2, stall on Rs1=9.
  - First WB to x9 → stall persists.
  - Second WB → stall clears the next cycle.
  - Simultaneous issue and WB on x9 leaves the count unchanged.
- Errors and flush:
  - Four issues to x4 with `SB_CNT_W`=2 → count 3 and `Sb_err_out`=1 (sticky).
  - WB to x6 at count 0 → `Sb_err_out`=1.
  - `Flush_in` with x4 pending → stall clears next cycle.
